// File: rtl/rga_bus_sequencer.sv
// rga_bus_sequencer
// Register-address bus sequencer for a Denise-style chip. Each CCK cycle, the
// sequencer latches the register address on the rising CCK event and decodes it.
// Reads snapshot a source, then drive the data bus until the falling CCK event.
// Writes capture the data bus on the first CCKQ transition and emit a one-clk
// strobe. A new rising CCK event that arrives before the current access has
// finished aborts that access and sets a sticky overrun flag.

module rga_bus_sequencer #(
    parameter logic [7:0] IDLE_RGA = 8'hFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cck,
    input  logic        cck_edge,
    input  logic        cckq_edge,
    input  logic        cfg_ecs,
    input  logic [7:0]  rga,
    input  logic [15:0] db_in,
    input  logic [15:0] deniseid,
    input  logic [15:0] clxdat,
    input  logic [15:0] joy0dat,
    input  logic [15:0] joy1dat,
    output logic [15:0] db_out,
    output logic        db_oen,
    output logic        wr_stb,
    output logic [7:0]  wr_addr,
    output logic [15:0] wr_data,
    output logic        clx_clr,
    output logic        ovr_err
);

    localparam logic [7:0] RGA_JOY0DAT  = 8'h05;
    localparam logic [7:0] RGA_JOY1DAT  = 8'h06;
    localparam logic [7:0] RGA_CLXDAT   = 8'h07;
    localparam logic [7:0] RGA_DENISEID = 8'h3E;

    typedef enum logic [2:0] {
        IDLE,
        DECODE,
        WR_WAIT,
        RD_DRIVE,
        TURN
    } stateType;

    stateType    r_state;
    logic [7:0]  r_rgaQ;
    logic [15:0] r_dbOut;
    logic        r_dbOen;
    logic        r_wrStb;
    logic [7:0]  r_wrAddr;
    logic [15:0] r_wrData;
    logic        r_clxClr;
    logic        r_ovrErr;

    logic        w_riseEvt;
    logic        w_fallEvt;
    logic        w_isRead;
    logic [15:0] w_readData;

    assign w_riseEvt = cck_edge & cck;
    assign w_fallEvt = cck_edge & ~cck;

    // Classify the latched address: which addresses are readable, and which
    // source each of them returns. DENISEID only exists on ECS parts; on OCS
    // the address falls through to the write path so the bus is never driven.
    always_comb begin
        w_isRead   = 1'b0;
        w_readData = 16'h0000;
        case (r_rgaQ)
            RGA_JOY0DAT: begin
                w_isRead   = 1'b1;
                w_readData = joy0dat;
            end
            RGA_JOY1DAT: begin
                w_isRead   = 1'b1;
                w_readData = joy1dat;
            end
            RGA_CLXDAT: begin
                w_isRead   = 1'b1;
                w_readData = clxdat;
            end
            RGA_DENISEID: begin
                w_isRead   = cfg_ecs;
                w_readData = deniseid;
            end
            default: begin
                w_isRead   = 1'b0;
                w_readData = 16'h0000;
            end
        endcase
    end

    // Access sequencer: one FSM with all bus outputs registered. A rising CCK
    // event outside IDLE takes priority over everything else, restarting the
    // decode with the new address and dropping any pending strobe or drive.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_rgaQ   <= 8'h00;
            r_dbOut  <= 16'h0000;
            r_dbOen  <= 1'b0;
            r_wrStb  <= 1'b0;
            r_wrAddr <= 8'h00;
            r_wrData <= 16'h0000;
            r_clxClr <= 1'b0;
            r_ovrErr <= 1'b0;
        end else begin
            r_wrStb  <= 1'b0;
            r_clxClr <= 1'b0;
            if (w_riseEvt && (r_state != IDLE)) begin
                r_ovrErr <= 1'b1;
                r_dbOen  <= 1'b0;
                r_rgaQ   <= rga;
                r_state  <= DECODE;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_riseEvt) begin
                            r_rgaQ  <= rga;
                            r_state <= DECODE;
                        end
                    end
                    DECODE: begin
                        if (r_rgaQ == IDLE_RGA) begin
                            r_state <= IDLE;
                        end else if (w_isRead) begin
                            r_dbOut <= w_readData;
                            r_dbOen <= 1'b1;
                            r_state <= RD_DRIVE;
                        end else begin
                            r_state <= WR_WAIT;
                        end
                    end
                    WR_WAIT: begin
                        if (cckq_edge) begin
                            r_wrAddr <= r_rgaQ;
                            r_wrData <= db_in;
                            r_wrStb  <= 1'b1;
                            r_state  <= IDLE;
                        end
                    end
                    RD_DRIVE: begin
                        if (w_fallEvt) begin
                            r_dbOen  <= 1'b0;
                            r_clxClr <= (r_rgaQ == RGA_CLXDAT);
                            r_state  <= TURN;
                        end
                    end
                    TURN: begin
                        r_state <= IDLE;
                    end
                    default: begin
                        r_dbOen <= 1'b0;
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign db_out  = r_dbOut;
    assign db_oen  = r_dbOen;
    assign wr_stb  = r_wrStb;
    assign wr_addr = r_wrAddr;
    assign wr_data = r_wrData;
    assign clx_clr = r_clxClr;
    assign ovr_err = r_ovrErr;

endmodule
